// File: rtl/pin_test_pkg.sv
// pin_test_pkg: shared mode encoding and synchroniser depth for the pin exerciser
package pin_test_pkg;
  typedef enum logic [1:0] {MODE_OFF, MODE_HIGH, MODE_SQUARE, MODE_STROBE} mode_e;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/pin_channel.sv
// pin_channel: one programmable divider with phase, mode decode and registered pin
module pin_channel
  import pin_test_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter logic [DIV_W-1:0] DIV_DEFAULT = DIV_W'(49999)
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             run,
  input  logic             load,
  input  logic [DIV_W-1:0] div_val,
  input  mode_e            mode,
  output logic             pin
);
  logic [DIV_W-1:0] count, div_reg;
  logic phase, tc, phase_nxt, pin_nxt;
  always_comb begin
    tc = run && !load && count == div_reg;
    phase_nxt = (!run || load) ? 1'b0 : phase ^ tc;
    pin_nxt = !run ? 1'b0 :
              mode == MODE_HIGH ? 1'b1 :
              mode == MODE_SQUARE ? phase_nxt :
              mode == MODE_STROBE ? tc : 1'b0;
  end
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      count <= '0;
      div_reg <= DIV_DEFAULT;
      phase <= 1'b0;
      pin <= 1'b0;
    end else begin
      div_reg <= load ? div_val : div_reg;
      count <= (!run || load || tc) ? '0 : count + DIV_W'(1);
      phase <= phase_nxt;
      pin <= pin_nxt;
    end
  end
endmodule

// File: rtl/pin_exerciser.sv
// pin_exerciser: N_CH divider-driven pins gated by synchronised locked and a debounced switch
module pin_exerciser
  import pin_test_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int DIV_W = 16,
  parameter logic [DIV_W-1:0] DIV_DEFAULT = DIV_W'(49999),
  parameter int DEB_CYC = 500000
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              locked,
  input  logic              switch_in,
  input  logic [N_CH-1:0]   div_load,
  input  logic [DIV_W-1:0]  div_val,
  input  logic [2*N_CH-1:0] mode,
  output logic [N_CH-1:0]   pin_out,
  output logic              sw_state,
  output logic              run
);
  localparam int DEB_W = $clog2(DEB_CYC);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
  logic [SYNC_STAGES-1:0] lock_sr, sw_sr;
  logic [DEB_W-1:0] deb_cnt;
  logic locked_sync, sw_sync, deb_done;
  assign locked_sync = lock_sr[SYNC_STAGES-1];
  assign sw_sync = sw_sr[SYNC_STAGES-1];
  assign deb_done = sw_sync != sw_state && deb_cnt == DEB_LAST;
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      lock_sr <= '0;
      sw_sr <= '0;
      deb_cnt <= '0;
      sw_state <= 1'b0;
      run <= 1'b0;
    end else begin
      lock_sr <= {lock_sr[SYNC_STAGES-2:0], locked};
      sw_sr <= {sw_sr[SYNC_STAGES-2:0], switch_in};
      deb_cnt <= (sw_sync == sw_state || deb_done) ? '0 : deb_cnt + DEB_W'(1);
      sw_state <= deb_done ? sw_sync : sw_state;
      run <= locked_sync & sw_state;
    end
  end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pin_channel #(.DIV_W(DIV_W), .DIV_DEFAULT(DIV_DEFAULT)) u_ch (
      .clk_in(clk_in),
      .rst_n(rst_n),
      .run(run),
      .load(div_load[i]),
      .div_val(div_val),
      .mode(mode_e'(mode[2*i+:2])),
      .pin(pin_out[i])
    );
  end
endmodule

// File: doc/pin_exerciser.md
# pin_exerciser

Parametrised multi-channel pin exerciser for board bring-up. Drives N_CH output pins from per-channel programmable dividers in one of four modes, gated by a debounced switch and a synchronised clock-wizard `locked` flag. Sits in a pin-test top directly behind the clock wizard, clocked by its output. Replaces the single-LED, fixed-divider pin test path.

## Interface
- N_CH, 4: number of output channels (1..16)
- DIV_W, 16: divider register width
- DIV_DEFAULT, 16'd49999: divider value loaded into every channel at reset
- DEB_CYC, 20'd500000: consecutive stable cycles required to accept a switch change (≥2)
- clk_in  in  1  system clock (clock-wizard output); only clock in the block
- rst_n  in  1  synchronous, active-low reset
- locked  in  1  clock-wizard lock, asynchronous to clk_in
- switch_in  in  1  raw board switch, asynchronous, bouncy
- div_load  in  N_CH  per-channel one-cycle strobe: load div_val into that channel
- div_val  in  DIV_W  divider value for div_load
- mode  in  2*N_CH  per-channel mode, channel i in bits [2i+1:2i]
- pin_out  out  N_CH  exercised pins, registered
- sw_state  out  1  debounced switch level
- run  out  1  global enable = locked_sync & sw_state

## Operation
- Modes (per channel): 0 OFF → pin 0; 1 HIGH → pin 1; 2 SQUARE → toggles at each terminal count; 3 STROBE → 1 for exactly one cycle per period.
- Per channel: count (DIV_W), div_reg (DIV_W), phase (1). count increments while run=1; when count == div_reg: count←0, phase←~phase (terminal count, TC).
- SQUARE period = 2*(div_reg+1) cycles, 50% duty. STROBE period = div_reg+1 cycles; pin high in the cycle after TC is detected.
- div_reg = 0: SQUARE toggles every cycle; STROBE holds pin constantly 1.
- div_load[i]=1: div_reg←div_val, count←0, phase←0 next edge; overrides TC in the same cycle. Multiple bits may be set together; all load the same div_val.
- run=0: all counts and phases held at 0, all pin_out 0 regardless of mode. Rising run restarts all channels phase-aligned from count 0.
- Mode change mid-period: takes effect on the next cycle's output; counter not disturbed.
- locked: 2-FF synchroniser → locked_sync.
- Switch: 2-FF synchroniser → sw_sync; debounce counter resets whenever sw_sync == sw_state, else increments; when it reaches DEB_CYC-1, sw_state←sw_sync and counter←0. Glitches shorter than DEB_CYC cycles never reach sw_state.
- Reset (rst_n=0 at edge): pin_out=0, sw_state=0, run=0, counts=0, phases=0, div_reg=DIV_DEFAULT, synchronisers=0, debounce counter=0. Reset mid-period aborts immediately; no partial pulse afterwards.

## Timing
- pin_out registered: mode change to HIGH/OFF visible 1 cycle later.
- locked rise → locked_sync after 2 edges → run after 3 edges (if sw_state=1).
- switch_in stable change → sw_state after 2 + DEB_CYC edges.
- run rise → first SQUARE toggle / STROBE pulse at edge div_reg+2 after run rises.
- div_load → new period starts counting the cycle after the load edge.

## Structure
- Package pin_test_pkg: mode enum (MODE_OFF, MODE_HIGH, MODE_SQUARE, MODE_STROBE, 2-bit) and sync stage-count constant.
- Sub-module pin_channel (one divider, phase, mode decode, output register), instantiated N_CH times by generate; synchronisers, debounce and run logic live in pin_exerciser.

## Test plan
- Reset then locked=1, switch_in=1 held: sw_state rises 2+DEB_CYC (DEB_CYC=8 in sim) edges later, run one edge after both; all pin_out 0 during reset.
- N_CH=4, DIV_W=8, load div_val=3 on all, modes {OFF,HIGH,SQUARE,STROBE}: pin0=0, pin1=1, pin2 period 8 duty 4, pin3 one-cycle pulse every 4 cycles.
- div_val=0 in SQUARE → pin toggles every cycle; in STROBE → constant 1.
- switch_in glitch of 5 cycles with DEB_CYC=8 → sw_state unchanged; 8+ stable cycles → sw_state follows.
- div_load asserted on the same cycle as a TC → count 0, phase 0, new period from div_val; no extra toggle.
- locked drops mid-period → run falls 3 edges later, all pins 0; locked re-asserted → all channels restart aligned at count 0.
